// File: rtl/mc_ctrl_pkg.sv
// Shared ManyCycleCPU control definitions: FSM state codes, opcodes, ALU codes,
// PC/register-destination select codes and the packed control word.
package mc_ctrl_pkg;

    localparam int OPCODE_W = 6;
    localparam int STATE_W  = 3;

    typedef enum logic [2:0] {
        S_IF    = 3'b000,
        S_ID    = 3'b001,
        S_EXE_A = 3'b110,
        S_EXE_B = 3'b101,
        S_EXE_M = 3'b010,
        S_MEM   = 3'b011,
        S_WB_A  = 3'b111,
        S_WB_L  = 3'b100
    } stateT;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef struct packed {
        logic       pcWre;
        logic       irWre;
        logic       regWre;
        logic [1:0] regDst;
        logic       wrRegDSrc;
        logic       dbDataSrc;
        logic       aluSrcA;
        logic       aluSrcB;
        logic       extSel;
        logic [2:0] aluOp;
        logic [1:0] pcSrc;
        logic       dataMemRW;
        logic       mRD;
    } ctrlWordT;

    function automatic logic isAluOp(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
            OP_SLL, OP_SLT, OP_SLTIU: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic isRType(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic isBranch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic isJump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode and Zero flow in, state plus every
// datapath enable and mux select flow out.
interface mc_control_unit_if
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = OPCODE_W,
    parameter int STW = STATE_W
);
    logic [OPW-1:0] insToCtrl;
    logic           Zero;
    logic [STW-1:0] State;
    logic           PCWre;
    logic           IRWre;
    logic           RegWre;
    logic [1:0]     RegDst;
    logic           WrRegDSrc;
    logic           DBDataSrc;
    logic           ALUSrcA;
    logic           ALUSrcB;
    logic           ExtSel;
    logic [2:0]     aluOp;
    logic [1:0]     pcSrc;
    logic           dataMemRW;
    logic           mRD;

    modport master (
        input  insToCtrl, Zero,
        output State, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
               ALUSrcA, ALUSrcB, ExtSel, aluOp, pcSrc, dataMemRW, mRD
    );

    modport slave (
        output insToCtrl, Zero,
        input  State, PCWre, IRWre, RegWre, RegDst, WrRegDSrc, DBDataSrc,
               ALUSrcA, ALUSrcB, ExtSel, aluOp, pcSrc, dataMemRW, mRD
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode from FSM state, opcode and ALU Zero.
// With HALT_EN defined, opcode 111111 is a real instruction rather than a NOP.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = OPCODE_W
) (
    input  stateT          state,
    input  logic           halted,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output ctrlWordT       cw
);

    logic knownOp;

    always_comb begin
        knownOp = isAluOp(opcode) | isBranch(opcode) | isMemOp(opcode) | isJump(opcode);
`ifdef HALT_EN
        if (opcode == OP_HALT) knownOp = 1'b1;
`endif
    end

    always_comb begin
        cw = '0;
        if (!halted) begin
            case (state)
                S_IF: cw.irWre = 1'b1;

                S_ID: begin
                    if (opcode == OP_J || opcode == OP_JAL) begin
                        cw.pcWre = 1'b1;
                        cw.pcSrc = PC_JUMP;
                    end
                    if (opcode == OP_JR) begin
                        cw.pcWre = 1'b1;
                        cw.pcSrc = PC_RS;
                    end
                    // jal links PC+4 into $31 in the same cycle the jump is taken
                    if (opcode == OP_JAL) begin
                        cw.regWre    = 1'b1;
                        cw.regDst    = RD_RA;
                        cw.wrRegDSrc = 1'b0;
                    end
                    if (!knownOp) cw.pcWre = 1'b1;
                end

                S_EXE_A, S_WB_A: begin
                    cw.aluSrcA = (opcode == OP_SLL);
                    cw.aluSrcB = (opcode == OP_ADDI) || (opcode == OP_ORI) || (opcode == OP_SLTIU);
                    cw.extSel  = (opcode == OP_ADDI) || (opcode == OP_SLTIU);
                    case (opcode)
                        OP_SUB:         cw.aluOp = ALU_SUB;
                        OP_OR, OP_ORI:  cw.aluOp = ALU_OR;
                        OP_AND:         cw.aluOp = ALU_AND;
                        OP_SLL:         cw.aluOp = ALU_SLL;
                        OP_SLT:         cw.aluOp = ALU_SLT;
                        OP_SLTIU:       cw.aluOp = ALU_SLTU;
                        default:        cw.aluOp = ALU_ADD;
                    endcase
                    // ALU selects stay up through write-back so DB holds the result
                    if (state == S_WB_A) begin
                        cw.pcWre     = 1'b1;
                        cw.regWre    = 1'b1;
                        cw.wrRegDSrc = 1'b1;
                        cw.dbDataSrc = 1'b0;
                        cw.regDst    = isRType(opcode) ? RD_RD : RD_RT;
                    end
                end

                S_EXE_B: begin
                    cw.aluOp   = ALU_SUB;
                    cw.aluSrcB = 1'b0;
                    cw.extSel  = 1'b1;
                    cw.pcWre   = 1'b1;
                    cw.pcSrc   = (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
                                 ? PC_BRANCH : PC_NEXT;
                end

                S_EXE_M, S_MEM: begin
                    cw.aluOp   = ALU_ADD;
                    cw.aluSrcB = 1'b1;
                    cw.extSel  = 1'b1;
                    if (state == S_MEM) begin
                        if (opcode == OP_SW) begin
                            cw.dataMemRW = 1'b1;
                            cw.pcWre     = 1'b1;
                        end else if (opcode == OP_LW) begin
                            cw.mRD = 1'b1;
                        end
                    end
                end

                S_WB_L: begin
                    cw.pcWre     = 1'b1;
                    cw.regWre    = 1'b1;
                    cw.regDst    = RD_RT;
                    cw.wrRegDSrc = 1'b1;
                    cw.dbDataSrc = 1'b1;
                end

                default: cw = '0;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// ManyCycleCPU multi-cycle control unit: instruction-phase FSM plus decode.
// Define HALT_EN to make opcode 111111 park the FSM until Reset.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = OPCODE_W,
    parameter int STW = STATE_W
) (
    input  logic               CLK,
    input  logic               Reset,
    mc_control_unit_if.master  bus
);

    stateT    stateQ, stateD;
    logic     haltQ;
    ctrlWordT cw, cwOut;

`ifdef HALT_EN
    logic haltD;
`else
    assign haltQ = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateQ <= S_IF;
`ifdef HALT_EN
            haltQ  <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
`ifdef HALT_EN
            haltQ  <= haltD;
`endif
        end
    end

    always_comb begin
        stateD = stateQ;
`ifdef HALT_EN
        haltD  = haltQ;
`endif
        if (!haltQ) begin
            case (stateQ)
                S_IF: stateD = S_ID;
                S_ID: begin
                    if (isBranch(bus.insToCtrl))      stateD = S_EXE_B;
                    else if (isMemOp(bus.insToCtrl))  stateD = S_EXE_M;
                    else if (isAluOp(bus.insToCtrl))  stateD = S_EXE_A;
                    else                              stateD = S_IF;
`ifdef HALT_EN
                    // halted shadow state keeps the visible code at ID
                    if (bus.insToCtrl == OP_HALT) begin
                        stateD = S_ID;
                        haltD  = 1'b1;
                    end
`endif
                end
                S_EXE_A: stateD = S_WB_A;
                S_WB_A:  stateD = S_IF;
                S_EXE_B: stateD = S_IF;
                S_EXE_M: stateD = S_MEM;
                S_MEM:   stateD = (bus.insToCtrl == OP_LW) ? S_WB_L : S_IF;
                S_WB_L:  stateD = S_IF;
                default: stateD = S_IF;
            endcase
        end
    end

    mc_ctrl_decode #(.OPW(OPW)) uDecode (
        .state  (stateQ),
        .halted (haltQ),
        .opcode (bus.insToCtrl),
        .zero   (bus.Zero),
        .cw     (cw)
    );

    // Reset overrides the IF decode so nothing is written while it is held
    assign cwOut = Reset ? '0 : cw;

    assign bus.State     = STW'(stateQ);
    assign bus.PCWre     = cwOut.pcWre;
    assign bus.IRWre     = cwOut.irWre;
    assign bus.RegWre    = cwOut.regWre;
    assign bus.RegDst    = cwOut.regDst;
    assign bus.WrRegDSrc = cwOut.wrRegDSrc;
    assign bus.DBDataSrc = cwOut.dbDataSrc;
    assign bus.ALUSrcA   = cwOut.aluSrcA;
    assign bus.ALUSrcB   = cwOut.aluSrcB;
    assign bus.ExtSel    = cwOut.extSel;
    assign bus.aluOp     = cwOut.aluOp;
    assign bus.pcSrc     = cwOut.pcSrc;
    assign bus.dataMemRW = cwOut.dataMemRW;
    assign bus.mRD       = cwOut.mRD;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle vector table plus reset and halt sequences.
module tb_mc_control_unit;

    logic CLK = 1'b0;
    logic Reset;

    mc_control_unit_if bus ();

    mc_control_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // select-field layout: {RegDst[1:0], WrRegDSrc, DBDataSrc, ALUSrcA, ALUSrcB, ExtSel, aluOp[2:0], pcSrc[1:0]}
    localparam logic [11:0] M_RD  = 12'hC00;
    localparam logic [11:0] M_WR  = 12'h200;
    localparam logic [11:0] M_DB  = 12'h100;
    localparam logic [11:0] M_A   = 12'h080;
    localparam logic [11:0] M_B   = 12'h040;
    localparam logic [11:0] M_EXT = 12'h020;
    localparam logic [11:0] M_ALU = 12'h01C;
    localparam logic [11:0] M_PC  = 12'h003;

    // enables layout: {PCWre, IRWre, RegWre, dataMemRW, mRD}
    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        zero;
        logic [2:0]  st;
        logic [4:0]  en;
        logic [11:0] mask;
        logic [11:0] sel;
    } vecT;

    vecT vecs[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [11:0] mkSel(input logic [1:0] rd, input logic wr, input logic db,
                                          input logic a, input logic b, input logic ext,
                                          input logic [2:0] alu, input logic [1:0] pc);
        return {rd, wr, db, a, b, ext, alu, pc};
    endfunction

    function automatic logic [4:0] actEn();
        return {bus.PCWre, bus.IRWre, bus.RegWre, bus.dataMemRW, bus.mRD};
    endfunction

    function automatic logic [11:0] actSel();
        return {bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ExtSel, bus.aluOp, bus.pcSrc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [5:0] op, input logic zero,
                          input logic [2:0] st, input logic [4:0] en,
                          input logic [11:0] mask, input logic [11:0] sel);
        vecT v;
        v.name = name; v.op = op; v.zero = zero; v.st = st;
        v.en = en; v.mask = mask; v.sel = sel;
        vecs.push_back(v);
    endtask

    task automatic addFetch(input string nm, input logic [5:0] op, input logic zero);
        addVec({nm, " IF"}, op, zero, 3'b000, 5'b01000, M_PC, 12'h000);
        addVec({nm, " ID"}, op, zero, 3'b001, 5'b00000, M_PC, 12'h000);
    endtask

    task automatic addAlu(input string nm, input logic [5:0] op, input logic a, input logic b,
                          input logic extCare, input logic ext, input logic [2:0] alu,
                          input logic [1:0] rd);
        logic [11:0] m;
        m = M_A | M_B | M_ALU | M_PC | (extCare ? M_EXT : 12'h000);
        addFetch(nm, op, 1'b0);
        addVec({nm, " EXE_A"}, op, 1'b1, 3'b110, 5'b00000, m, mkSel(2'b00, 0, 0, a, b, ext, alu, 2'b00));
        addVec({nm, " WB_A"}, op, 1'b0, 3'b111, 5'b10100, m | M_RD | M_WR | M_DB,
               mkSel(rd, 1, 0, a, b, ext, alu, 2'b00));
    endtask

    task automatic addBranch(input string nm, input logic [5:0] op, input logic zero,
                             input logic [1:0] pc);
        addFetch(nm, op, zero);
        addVec({nm, " EXE_B"}, op, zero, 3'b101, 5'b10000, M_B | M_EXT | M_ALU | M_PC,
               mkSel(2'b00, 0, 0, 0, 0, 1, 3'b001, pc));
    endtask

    task automatic addJumpLike(input string nm, input logic [5:0] op, input logic [4:0] en,
                               input logic [11:0] mask, input logic [11:0] sel);
        addVec({nm, " IF"}, op, 1'b0, 3'b000, 5'b01000, M_PC, 12'h000);
        addVec({nm, " ID"}, op, 1'b0, 3'b001, en, mask, sel);
    endtask

    initial begin
        // name, op, ALUSrcA, ALUSrcB, ExtSel cared, ExtSel, aluOp, RegDst
        addAlu("add",   6'b000000, 0, 0, 0, 0, 3'b000, 2'b10);
        addAlu("sub",   6'b000001, 0, 0, 0, 0, 3'b001, 2'b10);
        addAlu("addi",  6'b000010, 0, 1, 1, 1, 3'b000, 2'b01);
        addAlu("or",    6'b010000, 0, 0, 0, 0, 3'b011, 2'b10);
        addAlu("and",   6'b010001, 0, 0, 0, 0, 3'b100, 2'b10);
        addAlu("ori",   6'b010010, 0, 1, 1, 0, 3'b011, 2'b01);
        addAlu("sll",   6'b011000, 1, 0, 0, 0, 3'b010, 2'b10);
        addAlu("slt",   6'b100110, 0, 0, 0, 0, 3'b110, 2'b10);
        addAlu("sltiu", 6'b100111, 0, 1, 1, 1, 3'b101, 2'b01);

        addFetch("lw", 6'b110001, 1'b0);
        addVec("lw EXE_M", 6'b110001, 1'b0, 3'b010, 5'b00000, M_B | M_EXT | M_ALU | M_PC,
               mkSel(2'b00, 0, 0, 0, 1, 1, 3'b000, 2'b00));
        addVec("lw MEM",  6'b110001, 1'b0, 3'b011, 5'b00001, M_PC, 12'h000);
        addVec("lw WB_L", 6'b110001, 1'b0, 3'b100, 5'b10100, M_RD | M_WR | M_DB | M_PC,
               mkSel(2'b01, 1, 1, 0, 0, 0, 3'b000, 2'b00));

        addFetch("sw", 6'b110000, 1'b0);
        addVec("sw EXE_M", 6'b110000, 1'b0, 3'b010, 5'b00000, M_B | M_EXT | M_ALU | M_PC,
               mkSel(2'b00, 0, 0, 0, 1, 1, 3'b000, 2'b00));
        addVec("sw MEM", 6'b110000, 1'b0, 3'b011, 5'b10010, M_PC, 12'h000);

        addBranch("beq z1", 6'b110100, 1'b1, 2'b01);
        addBranch("beq z0", 6'b110100, 1'b0, 2'b00);
        addBranch("bne z0", 6'b110101, 1'b0, 2'b01);
        addBranch("bne z1", 6'b110101, 1'b1, 2'b00);

        addJumpLike("j",   6'b111000, 5'b10000, M_PC, 12'h003);
        addJumpLike("jr",  6'b111001, 5'b10000, M_PC, 12'h002);
        addJumpLike("jal", 6'b111010, 5'b10100, M_RD | M_WR | M_PC,
                    mkSel(2'b00, 0, 0, 0, 0, 0, 3'b000, 2'b11));
        addJumpLike("undef", 6'b001111, 5'b10000, M_PC, 12'h000);

        // reset held for two edges with a jal opcode present
        Reset = 1'b1;
        bus.insToCtrl = 6'b111010;
        bus.Zero = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK); #1;
            check("reset State", bus.State, 3'b000);
            check("reset enables", actEn(), 5'b00000);
            check("reset selects", actSel(), 12'h000);
        end
        Reset = 1'b0;

        foreach (vecs[i]) begin
            bus.insToCtrl = vecs[i].op;
            bus.Zero      = vecs[i].zero;
            #3;
            check({vecs[i].name, " State"}, bus.State, vecs[i].st);
            check({vecs[i].name, " enables"}, actEn(), vecs[i].en);
            check({vecs[i].name, " selects"}, actSel() & vecs[i].mask, vecs[i].sel & vecs[i].mask);
            @(posedge CLK); #1;
        end

        // asynchronous reset during sw MEM
        bus.insToCtrl = 6'b110000;
        bus.Zero = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("sw pre-reset State", bus.State, 3'b011);
        check("sw pre-reset dataMemRW", bus.dataMemRW, 1'b1);
        #1 Reset = 1'b1;
        #1;
        check("async reset State", bus.State, 3'b000);
        check("async reset dataMemRW", bus.dataMemRW, 1'b0);
        check("async reset PCWre", bus.PCWre, 1'b0);
        @(posedge CLK); #1;
        check("reset held State", bus.State, 3'b000);
        check("reset held enables", actEn(), 5'b00000);
        Reset = 1'b0;
        bus.insToCtrl = 6'b000000;
        #3;
        check("post-reset IF enables", actEn(), 5'b01000);
        @(posedge CLK); #1;
        check("post-reset ID State", bus.State, 3'b001);
        repeat (3) @(posedge CLK);
        #1;
        check("post-reset add done State", bus.State, 3'b000);

        // halt opcode
        bus.insToCtrl = 6'b111111;
        @(posedge CLK); #1;
`ifdef HALT_EN
        check("halt ID State", bus.State, 3'b001);
        check("halt ID enables", actEn(), 5'b00000);
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            check("halted State+enables", {bus.State, actEn()}, {3'b001, 5'b00000});
        end
        Reset = 1'b1;
        #1;
        check("halt reset State", bus.State, 3'b000);
        @(posedge CLK); #1;
        Reset = 1'b0;
        bus.insToCtrl = 6'b111000;
        #3;
        check("halt recover IF enables", actEn(), 5'b01000);
        @(posedge CLK); #1;
        check("halt recover j State", bus.State, 3'b001);
        check("halt recover j PCWre", bus.PCWre, 1'b1);
`else
        check("halt-as-nop ID State", bus.State, 3'b001);
        check("halt-as-nop ID enables", actEn(), 5'b10000);
        check("halt-as-nop pcSrc", bus.pcSrc, 2'b00);
        @(posedge CLK); #1;
        check("halt-as-nop back to IF", bus.State, 3'b000);
        check("halt-as-nop IF enables", actEn(), 5'b01000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle control unit for the ManyCycleCPU datapath. It holds the 3-bit instruction-phase FSM (IF/ID/EXE/MEM/WB) and decodes the 6-bit opcode (insToCtrl) and the ALU Zero flag. It drives every datapath enable and mux select: PC, IR, register file, data RAM, ALU.

Parameters:
OPW, 6, opcode width
STW, 3, state width (exported on State for bench observation)

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; forces state IF
insToCtrl  in  OPW  opcode field from the IR
Zero  in  1  ALU zero flag (combinational, from the current EXE cycle)
State  out  STW  current FSM state
PCWre  out  1  PC write enable
IRWre  out  1  instruction-register write enable
RegWre  out  1  register-file write enable
RegDst  out  2  write reg select: 00 = $31, 01 = rt, 10 = rd
WrRegDSrc  out  1  0 = PC+4, 1 = DB (ALU/RAM result)
DBDataSrc  out  1  0 = ALU result, 1 = RAM output
ALUSrcA  out  1  0 = rs, 1 = shamt
ALUSrcB  out  1  0 = rt, 1 = extended immediate
ExtSel  out  1  0 = zero-extend, 1 = sign-extend
aluOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 unsigned lt, 110 signed lt, 111 xor
pcSrc  out  2  00 PC+4, 01 branch PC+4+(imm<<2), 10 rs, 11 jump target
dataMemRW  out  1  0 = read, 1 = write (meaningful only in MEM)
mRD  out  1  RAM read strobe

Behaviour:
- State encoding: IF=000, ID=001, EXE_A=110, EXE_B=101, EXE_M=010, MEM=011, WB_A=111, WB_L=100.
- State register is the only sequential element. All other outputs are combinational from State, insToCtrl and Zero.
- Reset (async, any time, including mid-instruction): State=IF immediately. While Reset=1: PCWre=0, IRWre=0, RegWre=0, dataMemRW=0, mRD=0, all selects 0. On release, the first rising edge executes IF.
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010, sll 011000
  - slt 100110, sltiu 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101
  - j 111000, jr 111001, jal 111010, halt 111111
- Transitions:
  - IF->ID always.
  - ID->EXE_B for beq/bne.
  - ID->EXE_M for lw/sw.
  - ID->IF for j/jr/jal.
  - ID->EXE_A for R/I ALU ops.
  - EXE_A->WB_A->IF.
  - EXE_B->IF.
  - EXE_M->MEM. MEM->WB_L for lw, MEM->IF for sw. WB_L->IF.
- Cycle counts: j/jr/jal 2; beq/bne 3; ALU 4; sw 4; lw 5.
- IF: IRWre=1, all other write enables 0.
- PCWre is 1 only in the last cycle of each instruction: ID for jumps, EXE_B, WB_A, MEM for sw, WB_L.
- pcSrc:
  - 11 for j/jal, 10 for jr.
  - 01 in EXE_B when (beq & Zero) | (bne & ~Zero), else 00.
  - 00 everywhere else.
- jal in ID: RegWre=1, RegDst=00, WrRegDSrc=0.
- EXE_B: aluOp=001, ALUSrcB=0, ExtSel=1.
- EXE_M: aluOp=000, ALUSrcB=1, ExtSel=1.
- MEM: sw gives dataMemRW=1, mRD=0; lw gives mRD=1, dataMemRW=0.
- WB_A: RegWre=1, WrRegDSrc=1, DBDataSrc=0. RegDst=10 for R-type, 01 for addi/ori/sltiu.
- WB_L: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1.
- Decode in EXE_A/WB_A:
  - sll: ALUSrcA=1.
  - ori: ExtSel=0. addi and sltiu: ExtSel=1.
  - sltiu: aluOp=101. slt: aluOp=110.
- Undefined opcode: ID->IF, PCWre=1, pcSrc=00, no register or RAM write (NOP).
- Outputs held stable while state is held. No write enable may be asserted in two consecutive states for one instruction, except PCWre for two back-to-back instructions.

Optional Feature:
HALT_EN.
- Defined: halt (111111) in ID moves to state HLT=000 shadow, encoded as a separate 4th state bit kept internal. State output still reads 001. The FSM then stays in HLT with PCWre=0, IRWre=0, RegWre=0 and dataMemRW=0 until Reset.
- Undefined: 111111 is decoded as an undefined opcode (NOP, PC+4).

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - aluOp codes
  - pcSrc and RegDst codes
  The datapath and bench include the same package.
- One natural sub-module: mc_ctrl_decode. It is purely combinational (state, opcode, Zero -> control word). The FSM register stays in the top.

Test Plan:
- Reset=1 for 2 cycles, then release, opcode=000000 -> State sequence 000,001,110,111,000. RegWre=1 only in 111, with RegDst=10. PCWre=1 only in 111.
- lw (110001) -> states 000,001,010,011,100. mRD=1 in 011. RegWre=1, DBDataSrc=1, RegDst=01 in 100.
- beq with Zero=1, then with Zero=0 -> in EXE_B, pcSrc=01 in the first case and 00 in the second. PCWre=1 both times, 3 cycles each.
- jal (111010) -> 2 cycles. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, pcSrc=11.
- Reset asserted asynchronously mid-MEM of sw -> State=000 before the next edge, dataMemRW falls to 0 immediately, no PC update.
- halt (111111) -> with HALT_EN: PCWre stays 0 for 20 cycles, recovering only on Reset. Without HALT_EN: returns to IF after 2 cycles with pcSrc=00.
